// File: rtl/gnrl_arb_mux_pkg.sv
// rtl/gnrl_arb_mux_pkg.sv - arbitration mode encodings and channel-count bounds
package gnrl_arb_mux_pkg;

  localparam int ARB_RR      = 0;
  localparam int ARB_FIXED   = 1;

  localparam int CHN_NUM_MIN = 2;
  localparam int CHN_NUM_MAX = 16;

endpackage

// File: rtl/gnrl_rr_arbiter.sv
// rtl/gnrl_rr_arbiter.sv - combinational round-robin / fixed-priority one-hot arbiter
module gnrl_rr_arbiter
  import gnrl_arb_mux_pkg::*;
#(
  parameter int CHN_NUM  = 5,
  parameter int ARB_MODE = ARB_RR
) (
  input  logic [CHN_NUM-1:0] req,
  input  logic [CHN_NUM-1:0] last_grant,
  output logic [CHN_NUM-1:0] grant
);

  localparam int DW = 2 * CHN_NUM;

  logic [CHN_NUM-1:0] lg_shl;
  logic [CHN_NUM-1:0] mask;
  logic [DW-1:0]      dbl;
  logic [DW-1:0]      dbl_first;

  // Low half holds requests above the last winner; high half is the wrapped
  // copy, so the lowest set bit of the concatenation is the round-robin winner.
  // A zero mask collapses this to plain lowest-index priority.
  always_comb begin
    lg_shl    = last_grant << 1;
    mask      = (ARB_MODE == ARB_RR) ? ~(lg_shl - CHN_NUM'(1)) : '0;
    dbl       = {req, req & mask};
    dbl_first = dbl & (~dbl + DW'(1));
    grant     = dbl_first[DW-1:CHN_NUM] | dbl_first[CHN_NUM-1:0];
  end

endmodule

// File: rtl/gnrl_arb_mux.sv
// rtl/gnrl_arb_mux.sv - N-channel arbitrated valid/ready mux with registered output
module gnrl_arb_mux
  import gnrl_arb_mux_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CHN_NUM    = 5,
  parameter int ARB_MODE   = ARB_RR
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [CHN_NUM-1:0]            in_valid,
  input  logic [CHN_NUM*DATA_WIDTH-1:0] in_data,
  output logic [CHN_NUM-1:0]            in_ready,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [CHN_NUM-1:0]            out_sel,
  input  logic                          out_ready
);

  if (CHN_NUM < CHN_NUM_MIN || CHN_NUM > CHN_NUM_MAX) begin : g_cfg_err
    $error("gnrl_arb_mux: CHN_NUM must be within 2..16");
  end

  // Channel CHN_NUM-1 counts as the previous winner so channel 0 goes first.
  localparam logic [CHN_NUM-1:0] LG_RST = CHN_NUM'(1) << (CHN_NUM - 1);

  logic [CHN_NUM-1:0]    last_grant;
  logic [CHN_NUM-1:0]    grant;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  free;
  logic                  accept;

  gnrl_rr_arbiter #(
    .CHN_NUM  (CHN_NUM),
    .ARB_MODE (ARB_MODE)
  ) u_arb (
    .req        (in_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign free     = ~out_valid | out_ready;
  assign in_ready = grant & {CHN_NUM{free & rst_n}};
  assign accept   = |(in_valid & in_ready);

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < CHN_NUM; i++) begin
      sel_data = sel_data | (in_data[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant[i]}});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sel    <= '0;
      last_grant <= LG_RST;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_sel   <= grant;
      if (ARB_MODE == ARB_RR) begin
        last_grant <= grant;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gnrl_arb_mux.sv
// tb/tb_gnrl_arb_mux.sv - directed self-checking bench for gnrl_arb_mux
`timescale 1ns/1ps
module tb_gnrl_arb_mux;

    localparam int W = 32;
    localparam int N = 5;

    logic           clk;
    logic           rst_n;

    logic [N-1:0]   valid_a, ready_a, sel_a;
    logic [N*W-1:0] data_a;
    logic           ovalid_a, oready_a;
    logic [W-1:0]   odata_a;

    logic [N-1:0]   valid_b, ready_b, sel_b;
    logic [N*W-1:0] data_b;
    logic           ovalid_b, oready_b;
    logic [W-1:0]   odata_b;

    int passed = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        if (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    gnrl_arb_mux #(.DATA_WIDTH(W), .CHN_NUM(N), .ARB_MODE(0)) dut_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (valid_a),
        .in_data   (data_a),
        .in_ready  (ready_a),
        .out_valid (ovalid_a),
        .out_data  (odata_a),
        .out_sel   (sel_a),
        .out_ready (oready_a)
    );

    gnrl_arb_mux #(.DATA_WIDTH(W), .CHN_NUM(N), .ARB_MODE(1)) dut_fx (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (valid_b),
        .in_data   (data_b),
        .in_ready  (ready_b),
        .out_valid (ovalid_b),
        .out_data  (odata_b),
        .out_sel   (sel_b),
        .out_ready (oready_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $error("FAIL timeout: bench did not finish in time");
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_pattern();
        for (int i = 0; i < N; i++) begin
            data_a[i*W +: W] = 32'h1000_0000 + 32'(i);
            data_b[i*W +: W] = 32'h2000_0000 + 32'(i);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        valid_a  = 5'b11111;
        valid_b  = 5'b00000;
        oready_a = 1'b1;
        oready_b = 1'b1;
        load_pattern();
        #1;
        check("rst_out_valid", ovalid_a, 1'b0);
        check("rst_out_sel", sel_a, 5'b00000);
        check("rst_in_ready", ready_a, 5'b00000);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("first_in_ready", ready_a, 5'b00001);

        for (int k = 0; k < 6; k++) begin
            step();
            check("rr_out_valid", ovalid_a, 1'b1);
            check("rr_out_data", odata_a, 32'h1000_0000 + 32'(k % N));
        end
        check("rr_wrap_sel", sel_a, 5'b00001);

        step();
        step();
        step();
        check("rr_pre_alt_data", odata_a, 32'h1000_0003);

        valid_a = 5'b01010;
        #1;
        check("alt_ready_ch1", ready_a, 5'b00010);
        step();
        check("alt_data_ch1", odata_a, 32'h1000_0001);
        check("alt_ready_ch3", ready_a, 5'b01000);
        step();
        check("alt_data_ch3", odata_a, 32'h1000_0003);
        check("alt_ready_ch1b", ready_a, 5'b00010);
        step();
        check("alt_sel_ch1b", sel_a, 5'b00010);

        valid_a = 5'b00001;
        data_a[0*W +: W] = 32'hDEAD_BEEF;
        data_a[2*W +: W] = 32'h0000_2222;
        step();
        check("stall_load", odata_a, 32'hDEAD_BEEF);
        oready_a = 1'b0;
        valid_a  = 5'b00100;
        #1;
        check("stall_in_ready", ready_a, 5'b00000);
        for (int k = 0; k < 4; k++) begin
            step();
            check("stall_data", odata_a, 32'hDEAD_BEEF);
            check("stall_valid", ovalid_a, 1'b1);
            check("stall_ready", ready_a, 5'b00000);
        end
        oready_a = 1'b1;
        #1;
        check("unstall_ready", ready_a, 5'b00100);
        step();
        check("unstall_data", odata_a, 32'h0000_2222);
        check("unstall_valid", ovalid_a, 1'b1);
        check("unstall_sel", sel_a, 5'b00100);
        valid_a = 5'b00000;
        step();
        check("drain_valid", ovalid_a, 1'b0);
        check("drain_data_hold", odata_a, 32'h0000_2222);
        check("drain_sel_hold", sel_a, 5'b00100);

        load_pattern();
        valid_a = 5'b00001;
        step();
        check("pre_arst_valid", ovalid_a, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", ovalid_a, 1'b0);
        check("arst_data", odata_a, 32'h0000_0000);
        check("arst_sel", sel_a, 5'b00000);
        #1;
        rst_n   = 1'b1;
        valid_a = 5'b11111;
        #1;
        check("post_arst_ready", ready_a, 5'b00001);
        step();
        check("post_arst_sel", sel_a, 5'b00001);
        check("post_arst_data", odata_a, 32'h1000_0000);

        valid_b = 5'b10001;
        #1;
        check("fx_ready_ch0", ready_b, 5'b00001);
        for (int k = 0; k < 3; k++) begin
            step();
            check("fx_sel_ch0", sel_b, 5'b00001);
            check("fx_data_ch0", odata_b, 32'h2000_0000);
        end
        valid_b = 5'b10000;
        #1;
        check("fx_ready_ch4", ready_b, 5'b10000);
        step();
        check("fx_sel_ch4", sel_b, 5'b10000);
        check("fx_data_ch4", odata_b, 32'h2000_0004);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
